hs_rr_arbiter: RTL and testbench

HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

---
 rtl/hs_rr_arbiter_pkg.sv | 30 +++
 rtl/hs_rr_arbiter_if.sv | 30 +++
 rtl/hs_rr_arbiter_rr_grant.sv | 27 ++
 rtl/hs_rr_arbiter.sv | 87 ++++++++
 tb/tb_hs_rr_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hs_rr_arbiter_pkg.sv
// Shared constants and the rotating-priority search used by the round-robin arbiter.
package hs_rr_arbiter_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_DW = 8;
  localparam int MAX_N      = 8;
  localparam int SEARCH_W   = 3;

  // First set bit of elig visiting ptr, ptr+1, ... (mod n); returns 0 when none is set.
  function automatic logic [SEARCH_W-1:0] rr_search(input logic [MAX_N-1:0]    elig,
                                                    input logic [SEARCH_W-1:0] ptr,
                                                    input int                  n);
    logic [SEARCH_W-1:0] idx;
    logic                found;
    int                  j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (!found && elig[j[SEARCH_W-1:0]]) begin
          found = 1'b1;
          idx   = j[SEARCH_W-1:0];
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Upstream N-way request bus plus downstream single-beat bus of the round-robin arbiter.
interface hs_rr_arbiter_if
  import hs_rr_arbiter_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int DW  = DEFAULT_DW,
  parameter int IDW = $clog2(N)
);

  // Every channel is valid/ready: a beat moves in a cycle where both are 1 at the rising edge.
  logic [N-1:0]    valid_pre_i;
  logic [N*DW-1:0] data_pre_i;
  logic [N-1:0]    ready_pre_o;
  logic [N-1:0]    req_mask_i;
  logic            valid_post_o;
  logic [DW-1:0]   data_post_o;
  logic [IDW-1:0]  id_post_o;
  logic            ready_post_i;

  modport master (
    output valid_pre_i, data_pre_i, req_mask_i, ready_post_i,
    input  ready_pre_o, valid_post_o, data_post_o, id_post_o
  );

  modport slave (
    input  valid_pre_i, data_pre_i, req_mask_i, ready_post_i,
    output ready_pre_o, valid_post_o, data_post_o, id_post_o
  );

endinterface

// File: rtl/hs_rr_arbiter_rr_grant.sv
// Round-robin grant: one-hot grant, its index, and an any-eligible flag.
module rr_grant
  import hs_rr_arbiter_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] index,
  output logic           any
);

  logic [MAX_N-1:0]    elig_ext;
  logic [SEARCH_W-1:0] ptr_ext;
  logic [SEARCH_W-1:0] idx_ext;

  assign elig_ext = MAX_N'(eligible);
  assign ptr_ext  = SEARCH_W'(ptr);
  assign idx_ext  = rr_search(elig_ext, ptr_ext, N);

  assign any   = |eligible;
  assign index = IDW'(idx_ext);
  assign grant = any ? (N'(1) << index) : '0;

endmodule

// File: rtl/hs_rr_arbiter.sv
// N-to-1 round-robin arbiter with a registered output stage backed by one skid register.
module hs_rr_arbiter
  import hs_rr_arbiter_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int DW  = DEFAULT_DW,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  hs_rr_arbiter_if.slave  bus
);

  logic [N-1:0]   eligible;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           accept;
  logic           load_en;
  logic [DW-1:0]  in_data;

  logic [IDW-1:0] ptr_q;
  logic           out_valid_q;
  logic [DW-1:0]  out_data_q;
  logic [IDW-1:0] out_id_q;
  logic           skid_valid_q;
  logic [DW-1:0]  skid_data_q;
  logic [IDW-1:0] skid_id_q;

  assign eligible = bus.valid_pre_i & bus.req_mask_i;

  rr_grant #(.N(N), .IDW(IDW)) u_grant (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (gnt),
    .index    (gnt_idx),
    .any      (gnt_any)
  );

  // Upstream ready looks only at the skid, never at ready_post_i, so the stall path stays registered.
  assign bus.ready_pre_o = skid_valid_q ? '0 : gnt;
  assign accept          = gnt_any & ~skid_valid_q;
  assign load_en         = ~out_valid_q | bus.ready_post_i;
  assign in_data         = bus.data_pre_i[gnt_idx*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_id_q    <= '0;
    end else begin
      if (accept) begin
        ptr_q <= (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (load_en) begin
        if (skid_valid_q) begin
          out_valid_q  <= 1'b1;
          out_data_q   <= skid_data_q;
          out_id_q     <= skid_id_q;
          skid_valid_q <= 1'b0;
          skid_data_q  <= '0;
          skid_id_q    <= '0;
        end else if (accept) begin
          out_valid_q <= 1'b1;
          out_data_q  <= in_data;
          out_id_q    <= gnt_idx;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        // Output is held by a stall: park the beat so ordering is preserved.
        skid_valid_q <= 1'b1;
        skid_data_q  <= in_data;
        skid_id_q    <= gnt_idx;
      end
    end
  end

  assign bus.valid_post_o = out_valid_q;
  assign bus.data_post_o  = out_data_q;
  assign bus.id_post_o    = out_id_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: vector table, directed stall/reset sequences and a long random run.
module tb_hs_rr_arbiter;
  import hs_rr_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] mask;
    logic         rdy_post;
    logic [N-1:0] exp_rdy;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hs_rr_arbiter_if #(.N(N), .DW(DW)) bus();

  hs_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [IDW+DW-1:0] exp_q[$];
  vec_t              vecs[15];
  int                n_vec = 0;
  int                n_err = 0;
  int                mptr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] valid, input logic [N-1:0] mask,
                       input logic rdy_post, input logic fixed_data);
    bus.valid_pre_i  = valid;
    bus.req_mask_i   = mask;
    bus.ready_post_i = rdy_post;
    for (int i = 0; i < N; i++)
      bus.data_pre_i[i*DW +: DW] = fixed_data ? DW'(8'h10 + i) : DW'($urandom_range(0, 255));
  endtask

  // Reference: skid is full exactly when two beats are in flight.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int           idx;
    r = '0;
    if (exp_q.size() < 2) begin
      for (int k = N-1; k >= 0; k--) begin
        idx = (mptr + k) % N;
        if (bus.valid_pre_i[idx] && bus.req_mask_i[idx]) r = N'(1) << idx;
      end
    end
    return r;
  endfunction

  task automatic step(input logic use_model, input logic [N-1:0] tab_exp);
    logic [N-1:0]      exp_r;
    logic [IDW+DW-1:0] beat;
    int                gi;
    @(negedge clk);
    exp_r = use_model ? model_ready() : tab_exp;
    check("ready_pre", 32'(bus.ready_pre_o), 32'(exp_r));
    check("valid_post", 32'(bus.valid_post_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("beat_id_data", 32'({bus.id_post_o, bus.data_post_o}), 32'(exp_q[0]));
      if (bus.ready_post_i) void'(exp_q.pop_front());
    end
    if (exp_r != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (exp_r[i]) gi = i;
      beat = {IDW'(gi), bus.data_pre_i[gi*DW +: DW]};
      exp_q.push_back(beat);
      mptr = (gi + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, 4'b0010};
    vecs[2]  = '{4'hA, 4'hF, 1'b1, 4'b1000};
    vecs[3]  = '{4'hA, 4'hF, 1'b1, 4'b0010};
    vecs[4]  = '{4'hF, 4'hB, 1'b1, 4'b1000};
    vecs[5]  = '{4'hF, 4'hB, 1'b1, 4'b0001};
    vecs[6]  = '{4'h0, 4'hF, 1'b1, 4'b0000};
    vecs[7]  = '{4'h4, 4'hF, 1'b1, 4'b0100};
    vecs[8]  = '{4'h1, 4'hF, 1'b1, 4'b0001};
    vecs[9]  = '{4'hF, 4'h0, 1'b1, 4'b0000};
    vecs[10] = '{4'hF, 4'hF, 1'b1, 4'b0010};
    vecs[11] = '{4'hF, 4'hF, 1'b0, 4'b0100};
    vecs[12] = '{4'hF, 4'hF, 1'b0, 4'b0000};
    vecs[13] = '{4'hF, 4'hF, 1'b1, 4'b0000};
    vecs[14] = '{4'hF, 4'hF, 1'b1, 4'b1000};

    // Clock/reset
    drive(4'h0, 4'hF, 1'b1, 1'b1);
    #1;
    check("rst_valid_post", 32'(bus.valid_post_o), 32'd0);
    check("rst_data_post", 32'(bus.data_post_o), 32'd0);
    check("rst_id_post", 32'(bus.id_post_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].valid, vecs[v].mask, vecs[v].rdy_post, 1'b1);
      step(1'b0, vecs[v].exp_rdy);
    end

    // Full-rate streaming, then alternating pair 1/3
    for (int c = 0; c < 9; c++) begin
      drive(4'hF, 4'hF, 1'b1, 1'b1);
      step(1'b1, '0);
    end
    for (int c = 0; c < 6; c++) begin
      drive(4'hA, 4'hF, 1'b1, 1'b1);
      step(1'b1, '0);
    end

    // Three-cycle downstream stall mid-stream, then drain
    for (int c = 0; c < 12; c++) begin
      drive(4'hF, 4'hF, (c < 3 || c > 5), 1'b0);
      step(1'b1, '0);
    end

    // Reset while output and skid are both full
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, 4'hF, 1'b0, 1'b0);
      step(1'b1, '0);
    end
    check("fill_depth", 32'(exp_q.size()), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_post", 32'(bus.valid_post_o), 32'd0);
    check("midrst_ready_pre", 32'(bus.ready_pre_o), 32'b0001);
    exp_q.delete();
    mptr = 0;
    bus.valid_pre_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(4'hF, 4'hF, 1'b1, 1'b1);
    step(1'b0, 4'b0001);

    // Random valid/mask/ready
    for (int c = 0; c < 10000; c++) begin
      drive(4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
            ($urandom_range(0, 3) != 0), 1'b0);
      step(1'b1, '0);
    end

    // Drain and confirm nothing is left in flight
    for (int c = 0; c < 4; c++) begin
      drive(4'h0, 4'hF, 1'b1, 1'b0);
      step(1'b1, '0);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
